// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : fifo_pkg
// Purpose  : Shared pointer-coding helpers and defaults for the async FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int c_ADDR_WIDTH = 5;

  // Operands are zero-extended into 32 bits, so the codings hold for any
  // pointer width up to 32; callers truncate the result to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray value the write pointer holds when exactly one lap ahead of rq.
  function automatic logic [31:0] full_target(input logic [31:0] rq,
                                              input int unsigned ptr_w);
    return rq ^ (32'h3 << (ptr_w - 2));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync_2ff.sv
//------------------------------------------------------------------------------
// Module   : fifo_sync_2ff
// Purpose  : Parameterized-width two-flop synchronizer with synchronous reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_sync_2ff #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_ptr_full.sv
//------------------------------------------------------------------------------
// Module   : fifo_wr_ptr_full
// Purpose  : Write-side pointer, full/almost-full and level for the async FIFO.
//            Define FIFO_WR_SYNC_EN to synchronize RD_PTR_GRAY internally.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wr_ptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = c_ADDR_WIDTH,
  parameter int AFULL_THRESH = 28
) (
  input  logic                CLK_WRITE,
  input  logic                WR_RST,
  input  logic                WR_EN,
  input  logic [ADDR_WIDTH:0] RD_PTR_GRAY,
  output logic [ADDR_WIDTH:0] ADDR_WR,
  output logic [ADDR_WIDTH:0] WR_PTR_GRAY,
  output logic                FULL_FLAG,
  output logic                ALMOST_FULL,
  output logic [ADDR_WIDTH:0] WR_LEVEL,
  output logic                WR_ACCEPT,
  output logic                OVERFLOW
);

  localparam int c_PW = ADDR_WIDTH + 1;

  logic [c_PW-1:0] w_rq;
  logic [c_PW-1:0] w_rbin;
  logic            w_accept;
  logic [c_PW-1:0] w_wbin_next;
  logic [c_PW-1:0] w_wgray_next;
  logic [c_PW-1:0] w_full_gray;
  logic [c_PW-1:0] w_level_next;
  logic            w_full_next;
  logic            w_afull_next;

`ifdef FIFO_WR_SYNC_EN
  fifo_sync_2ff #(
    .WIDTH (c_PW)
  ) u_rd_ptr_sync (
    .clk (CLK_WRITE),
    .rst (WR_RST),
    .i_d (RD_PTR_GRAY),
    .o_q (w_rq)
  );
`else
  assign w_rq = RD_PTR_GRAY;
`endif

  assign w_accept     = WR_EN & ~FULL_FLAG;
  assign w_wbin_next  = ADDR_WR + {{ADDR_WIDTH{1'b0}}, w_accept};
  assign w_wgray_next = c_PW'(bin2gray(32'(w_wbin_next)));
  assign w_rbin       = c_PW'(gray2bin(32'(w_rq)));
  assign w_full_gray  = c_PW'(full_target(32'(w_rq), c_PW));

  // Flags are computed from the post-write pointer so the edge that takes
  // the last free slot also raises FULL_FLAG.
  assign w_full_next  = (w_wgray_next == w_full_gray);
  assign w_level_next = w_wbin_next - w_rbin;
  assign w_afull_next = (32'(w_level_next) >= 32'(AFULL_THRESH));

  always_ff @(posedge CLK_WRITE) begin
    if (WR_RST) begin
      ADDR_WR     <= '0;
      WR_PTR_GRAY <= '0;
      FULL_FLAG   <= 1'b0;
      ALMOST_FULL <= 1'b0;
      WR_LEVEL    <= '0;
      WR_ACCEPT   <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      ADDR_WR     <= w_wbin_next;
      WR_PTR_GRAY <= w_wgray_next;
      FULL_FLAG   <= w_full_next;
      ALMOST_FULL <= w_afull_next;
      WR_LEVEL    <= w_level_next;
      WR_ACCEPT   <= w_accept;
      OVERFLOW    <= OVERFLOW | (WR_EN & FULL_FLAG);
    end
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_ptr_full.md
Name: fifo_wr_ptr_full

Overview:
Write-side pointer and full-flag controller for the asynchronous FIFO; sits directly upstream of the dual-clock FIFO memory.
- Drives the memory's write address (ADDR_WR) and FULL_FLAG.
- Publishes a Gray-coded write pointer for the read domain.
- Derives full, almost-full and fill level from a Gray read pointer returned from the read domain.
- Runs entirely in the write clock domain.

Parameters:
ADDR_WIDTH, 5, memory address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; minimum 2.
AFULL_THRESH, 28, fill level at or above which ALMOST_FULL asserts; legal range 1..2**ADDR_WIDTH.

Ports:
CLK_WRITE  in  1  write-domain clock; all logic on rising edge.
WR_RST  in  1  synchronous, active-high reset.
WR_EN  in  1  write request from the producer.
RD_PTR_GRAY  in  ADDR_WIDTH+1  Gray-coded read pointer from the read domain.
ADDR_WR  out  ADDR_WIDTH+1  registered binary write pointer; the memory uses the low ADDR_WIDTH bits.
WR_PTR_GRAY  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
FULL_FLAG  out  1  registered full indication.
ALMOST_FULL  out  1  registered; fill level >= AFULL_THRESH.
WR_LEVEL  out  ADDR_WIDTH+1  registered fill level, 0..2**ADDR_WIDTH.
WR_ACCEPT  out  1  registered one-cycle pulse; a write was accepted on the previous edge.
OVERFLOW  out  1  sticky error: a write was attempted while full.

Behaviour:
- Reset: WR_RST=1 at a rising edge of CLK_WRITE clears all registers; all outputs read 0.
  - Applies mid-operation; a WR_EN on the reset edge is discarded.
- Accept rule:
  - accept = WR_EN & ~FULL_FLAG.
  - wbin_next = ADDR_WR + accept, modulo 2**(ADDR_WIDTH+1).
  - ADDR_WR <= wbin_next; WR_PTR_GRAY <= wbin_next ^ (wbin_next >> 1).
- ADDR_WR is valid for the memory in the same cycle WR_EN is presented.
  - The memory writes at the old ADDR_WR using its own FULL_FLAG gate, which is this block's FULL_FLAG, so both gates agree.
- Read pointer: rq = RD_PTR_GRAY, or its synchronized copy when FIFO_WR_SYNC_EN is defined.
  - rbin = gray2bin(rq).
- Full detection:
  - FULL_FLAG <= (gray(wbin_next) == {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]}).
  - Asserts on the same edge that accepts the final free slot; zero-cycle write-to-full latency.
- Level:
  - WR_LEVEL <= (wbin_next - rbin) modulo 2**(ADDR_WIDTH+1).
  - Never exceeds 2**ADDR_WIDTH.
  - Pessimistic: overestimates while the read pointer is in flight, never underestimates.
- ALMOST_FULL <= (level_next >= AFULL_THRESH), evaluated on the same next-state level.
- WR_ACCEPT <= accept.
- OVERFLOW:
  - Set when WR_EN & FULL_FLAG.
  - Cleared only by WR_RST.
  - The pointer does not move on an overflow attempt.
- Wrap-around: the pointer rolls from 2**(ADDR_WIDTH+1)-1 to 0; the MSB toggles once per lap. Full/level stay correct across the wrap.
- Simultaneous write and read-pointer advance while full:
  - FULL_FLAG gates the write that cycle.
  - FULL_FLAG deasserts on the edge after the advanced rq is seen.
- Full release latency after a read-domain pop: 1 edge from the rq change without the sync option, 3 edges with it.

Optional Feature:
Macro FIFO_WR_SYNC_EN.
- Defined:
  - RD_PTR_GRAY passes through an internal two-flop synchronizer clocked by CLK_WRITE and reset by WR_RST.
  - Adds 2 cycles to full-release and level-update latency.
- Undefined:
  - RD_PTR_GRAY is used directly; it must already be synchronized to CLK_WRITE externally.

Decomposition:
- Shared package fifo_pkg:
  - bin2gray and gray2bin functions, parameterized on width.
  - Default ADDR_WIDTH constant.
  - The full-compare helper (inverted top two Gray bits).
- One natural sub-module, fifo_sync_2ff: parameterized-width two-flop synchronizer. Instantiated only under FIFO_WR_SYNC_EN; reused by the read-side controller.

Test Plan:
All scenarios use ADDR_WIDTH=5 and AFULL_THRESH=28, macro undefined unless stated.
- Reset, RD_PTR_GRAY=0, WR_EN=1 for 32 cycles:
  - FULL_FLAG=1 on the edge of the 32nd accept.
  - ADDR_WR=6'b100000, WR_PTR_GRAY=6'b110000, WR_LEVEL=32.
  - ALMOST_FULL rose on the edge where WR_LEVEL became 28.
- Continue WR_EN=1 while full for 3 cycles:
  - ADDR_WR holds at 32; WR_ACCEPT=0; OVERFLOW=1 and stays 1.
- Drive RD_PTR_GRAY=6'b000001 while full:
  - Next edge: FULL_FLAG=0, WR_LEVEL=31.
  - With FIFO_WR_SYNC_EN, FULL_FLAG clears on the third edge.
- 100 writes with RD_PTR_GRAY tracking the write pointer minus 4 (Gray):
  - Final ADDR_WR=36 (100 mod 64), WR_PTR_GRAY=6'b110110.
  - WR_LEVEL=4 throughout; FULL_FLAG never asserts.
- Assert WR_RST for one edge mid-burst with WR_EN=1:
  - All outputs 0 after that edge; the write on the reset edge is not counted.
  - The next accepted write yields ADDR_WR=1.
- Write and advance the read pointer by 1 on the same edge at level 27:
  - WR_LEVEL stays 27; ALMOST_FULL stays 0.
